// File: rtl/mcycle_muldiv.sv
// Iterative signed/unsigned multiply and restoring divide, one result bit per cycle.
// Optional macro MCYCLE_DIV0_FAST_EN: a divide by zero skips COMPUTE and finishes at t+2.
module mcycle_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, FIXUP} state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, raw1_q, raw1_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d;

  logic             sign1, sign2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign sign1 = MCycleOp[0] & Operand1[WIDTH-1];
  assign sign2 = MCycleOp[0] & Operand2[WIDTH-1];
  assign mag1  = sign1 ? -Operand1 : Operand1;
  assign mag2  = sign2 ? -Operand2 : Operand2;

  // Multiply: {hi,lo} holds partial product with the multiplier shifting out of lo.
  assign addend  = lo_q[0] ? a_q : '0;
  assign mul_sum = {1'b0, hi_q} + {1'b0, addend};

  // Divide: partial remainder is WIDTH+1 bits once the next dividend bit is shifted in.
  assign rem_sh  = {hi_q, lo_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - b_q;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = rneg_q ? -hi_q : hi_q;

  assign Busy    = (state_q == IDLE && Start) || (state_q != IDLE);
  assign Done    = done_q;
  assign Result1 = r1_q;
  assign Result2 = r2_q;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    raw1_d   = raw1_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          is_div_d = MCycleOp[1];
          neg_d    = sign1 ^ sign2;
          rneg_d   = sign1;
          div0_d   = MCycleOp[1] && (Operand2 == '0);
          a_d      = mag1;
          b_d      = mag2;
          raw1_d   = Operand1;
          hi_d     = '0;
          lo_d     = MCycleOp[1] ? mag1 : mag2;
          cnt_d    = '0;
`ifdef MCYCLE_DIV0_FAST_EN
          state_d  = (MCycleOp[1] && (Operand2 == '0)) ? FIXUP : COMPUTE;
`else
          state_d  = COMPUTE;
`endif
        end
      end
      COMPUTE: begin
        if (is_div_q) begin
          hi_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], rem_ge};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div0_q) begin
          r1_d = '1;
          r2_d = raw1_q;
        end else if (is_div_q) begin
          r1_d = quo_fix;
          r2_d = rem_fix;
        end else begin
          r1_d = prod_fix[WIDTH-1:0];
          r2_d = prod_fix[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      raw1_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      raw1_q   <= raw1_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
    end
  end

endmodule
